// File: rtl/axis_read_sched_pkg.sv
// Shared encodings for the stream read scheduler: FSM state indices and
// one-hot encoding, AXI INCR burst type and the 4 KB address boundary.
package axis_read_sched_pkg;

  localparam int IDLE       = 0;
  localparam int CONFIG     = 1;
  localparam int CALC       = 2;
  localparam int ADDR       = 3;
  localparam int DRAIN      = 4;
  localparam int NUM_STATES = 5;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int BOUNDARY_BYTES = 4096;
  localparam int BOUNDARY_BITS  = 12;

  // One-hot: bit position equals the state index above.
  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE   = 5'b00001,
    ST_CONFIG = 5'b00010,
    ST_CALC   = 5'b00100,
    ST_ADDR   = 5'b01000,
    ST_DRAIN  = 5'b10000
  } state_e;

endpackage

// File: rtl/axis_read_sched_if.sv
// Command, data-channel config and AXI AR/R monitor signals of the read
// scheduler; master is the scheduler side, slave the surrounding system.
interface axis_read_sched_if #(
  parameter int CONFIG_AWIDTH = 32,
  parameter int CONFIG_DWIDTH = 32,
  parameter int AXI_LEN_WIDTH = 8
);
  logic [CONFIG_AWIDTH-1:0] cfg_address;
  logic [CONFIG_DWIDTH-1:0] cfg_length;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [CONFIG_DWIDTH-1:0] data_cfg_length;
  logic                     data_cfg_valid;
  logic                     data_cfg_ready;
  logic [CONFIG_AWIDTH-1:0] axi_araddr;
  logic [AXI_LEN_WIDTH-1:0] axi_arlen;
  logic [2:0]               axi_arsize;
  logic [1:0]               axi_arburst;
  logic                     axi_arvalid;
  logic                     axi_arready;
  logic                     axi_rlast;
  logic                     axi_rvalid;
  logic                     axi_rready;
  logic [1:0]               axi_rresp;
  logic                     done;
  logic                     rresp_err;

  modport master (
    input  cfg_address, cfg_length, cfg_valid, data_cfg_ready, axi_arready,
           axi_rlast, axi_rvalid, axi_rready, axi_rresp,
    output cfg_ready, data_cfg_length, data_cfg_valid, axi_araddr, axi_arlen,
           axi_arsize, axi_arburst, axi_arvalid, done, rresp_err
  );

  modport slave (
    output cfg_address, cfg_length, cfg_valid, data_cfg_ready, axi_arready,
           axi_rlast, axi_rvalid, axi_rready, axi_rresp,
    input  cfg_ready, data_cfg_length, data_cfg_valid, axi_araddr, axi_arlen,
           axi_arsize, axi_arburst, axi_arvalid, done, rresp_err
  );
endinterface

// File: rtl/axis_read_burst_calc.sv
// Registered burst size: min(remaining beats, BURST_MAX, beats left before the
// next 4 KB boundary), loaded when calc_i is high.
module axis_read_burst_calc
  import axis_read_sched_pkg::*;
#(
  parameter int REM_WIDTH      = 33,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_MAX      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calc_i,
  input  logic [REM_WIDTH-1:0]     remaining_i,
  input  logic [BOUNDARY_BITS-1:0] addr_i,
  output logic [8:0]               burst_o,
  output logic [AXI_LEN_WIDTH-1:0] arlen_o
);

  localparam int BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [BOUNDARY_BITS:0] BOUND_FULL = BOUNDARY_BYTES[BOUNDARY_BITS:0];

  logic [BOUNDARY_BITS:0]   to_bound;
  logic [REM_WIDTH-1:0]     bound_ext;
  logic [REM_WIDTH-1:0]     max_ext;
  logic [REM_WIDTH-1:0]     pick;
  logic [8:0]               burst_q;
  logic [AXI_LEN_WIDTH-1:0] arlen_q;

  always_comb begin
    // Address is beat aligned, so the division by bytes-per-beat is exact.
    to_bound  = (BOUND_FULL - {1'b0, addr_i}) >> BEAT_SHIFT;
    bound_ext = REM_WIDTH'(to_bound);
    max_ext   = REM_WIDTH'(BURST_MAX);
    pick      = remaining_i;
    if (max_ext < pick) begin
      pick = max_ext;
    end
    if (bound_ext < pick) begin
      pick = bound_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
      arlen_q <= '0;
    end else if (calc_i) begin
      burst_q <= 9'(pick);
      arlen_q <= AXI_LEN_WIDTH'(pick - REM_WIDTH'(1));
    end
  end

  assign burst_o = burst_q;
  assign arlen_o = arlen_q;

endmodule

// File: rtl/axis_read_sched.sv
// Stream read scheduler: forwards the command length to the read data channel
// and issues 4 KB-safe AXI INCR read bursts with a bounded in-flight count.
// Optional sticky R error flag under `define AXIS_READ_SCHED_RRESP_EN.
//
// state  | meaning
// IDLE   | cfg_ready high, waiting for a command
// CONFIG | data_cfg_valid high until the read data channel takes the length
// CALC   | burst size registered from remaining beats, address and BURST_MAX
// ADDR   | arvalid offered while in-flight < OUTSTANDING
// DRAIN  | all bursts issued, waiting for the last rlast, then done
module axis_read_sched
  import axis_read_sched_pkg::*;
#(
  parameter int CONFIG_AWIDTH  = 32,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 16,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_MAX      = 16,
  parameter int OUTSTANDING    = 4
) (
  input logic               clk,
  input logic               rst_n,
  axis_read_sched_if.master bus
);

  localparam int RW          = CONFIG_DWIDTH + 1;
  localparam int RATIO_SHIFT = $clog2(WIDTH_RATIO);
  localparam int BEAT_SHIFT  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IW          = $clog2(OUTSTANDING + 1);
  localparam logic [CONFIG_DWIDTH-1:0] RATIO_MASK = CONFIG_DWIDTH'(WIDTH_RATIO - 1);
  localparam logic [IW-1:0]            OUT_MAX    = IW'(OUTSTANDING);

  state_e                   state_q;
  logic [CONFIG_AWIDTH-1:0] addr_q;
  logic [CONFIG_DWIDTH-1:0] length_q;
  logic [RW-1:0]            remaining_q;
  logic [IW-1:0]            inflight_q;
  logic [IW-1:0]            inflight_d;
  logic                     cfg_ready_q;
  logic                     data_cfg_valid_q;
  logic                     arvalid_q;
  logic                     done_q;

  logic [CONFIG_DWIDTH-1:0] len_eff;
  logic [RW-1:0]            beats_d;
  logic                     cfg_hs;
  logic                     ar_hs;
  logic                     dec_ok;
  logic [8:0]               burst;
  logic [AXI_LEN_WIDTH-1:0] arlen;

  always_comb begin
    // A zero length is taken as one word so the command still completes.
    len_eff  = (bus.cfg_length == '0) ? CONFIG_DWIDTH'(1) : bus.cfg_length;
    beats_d  = RW'(len_eff >> RATIO_SHIFT) + RW'(|(len_eff & RATIO_MASK));
    cfg_hs   = cfg_ready_q & bus.cfg_valid;
    ar_hs    = arvalid_q & bus.axi_arready;
    dec_ok   = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast & (inflight_q != '0);
    inflight_d = inflight_q;
    if (ar_hs && !dec_ok) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!ar_hs && dec_ok) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  axis_read_burst_calc #(
    .REM_WIDTH      (RW),
    .AXI_LEN_WIDTH  (AXI_LEN_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .BURST_MAX      (BURST_MAX)
  ) u_burst_calc (
    .clk         (clk),
    .rst_n       (rst_n),
    .calc_i      (state_q == ST_CALC),
    .remaining_i (remaining_q),
    .addr_i      (addr_q[BOUNDARY_BITS-1:0]),
    .burst_o     (burst),
    .arlen_o     (arlen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      length_q         <= '0;
      remaining_q      <= '0;
      inflight_q       <= '0;
      cfg_ready_q      <= 1'b1;
      data_cfg_valid_q <= 1'b0;
      arvalid_q        <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_hs) begin
            addr_q           <= bus.cfg_address;
            length_q         <= len_eff;
            remaining_q      <= beats_d;
            cfg_ready_q      <= 1'b0;
            data_cfg_valid_q <= 1'b1;
            state_q          <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (bus.data_cfg_ready) begin
            data_cfg_valid_q <= 1'b0;
            state_q          <= ST_CALC;
          end
        end
        ST_CALC: begin
          state_q   <= ST_ADDR;
          arvalid_q <= (inflight_d < OUT_MAX);
        end
        ST_ADDR: begin
          // inflight_d only falls while waiting, so a raised arvalid stays up.
          if (ar_hs) begin
            arvalid_q   <= 1'b0;
            addr_q      <= addr_q + (CONFIG_AWIDTH'(burst) << BEAT_SHIFT);
            remaining_q <= remaining_q - RW'(burst);
            state_q     <= (remaining_q == RW'(burst)) ? ST_DRAIN : ST_CALC;
          end else begin
            arvalid_q <= (inflight_d < OUT_MAX);
          end
        end
        ST_DRAIN: begin
          if (inflight_d == '0) begin
            done_q      <= 1'b1;
            cfg_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          cfg_ready_q      <= 1'b1;
          data_cfg_valid_q <= 1'b0;
          arvalid_q        <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_READ_SCHED_RRESP_EN
  logic rresp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rresp_err_q <= 1'b0;
    end else if (cfg_hs) begin
      rresp_err_q <= 1'b0;
    end else if (bus.axi_rvalid && bus.axi_rready && (bus.axi_rresp != 2'b00)) begin
      rresp_err_q <= 1'b1;
    end
  end

  assign bus.rresp_err = rresp_err_q;
`else
  assign bus.rresp_err = 1'b0;
`endif

  assign bus.cfg_ready       = cfg_ready_q;
  assign bus.data_cfg_length = length_q;
  assign bus.data_cfg_valid  = data_cfg_valid_q;
  assign bus.axi_araddr      = addr_q;
  assign bus.axi_arlen       = arlen;
  assign bus.axi_arsize      = 3'(BEAT_SHIFT);
  assign bus.axi_arburst     = AXI_BURST_INCR;
  assign bus.axi_arvalid     = arvalid_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_axis_read_sched.sv
// Bench for axis_read_sched: directed and random commands against a burst-list
// model built from 4 KB / BURST_MAX / ceil-length arithmetic.
module tb_axis_read_sched;

  localparam int  AW   = 32;
  localparam int  DW   = 32;
  localparam int  WR   = 16;
  localparam int  LW   = 8;
  localparam int  ADW  = 32;
  localparam int  BMAX = 32;
  localparam int  OUTS = 2;
  localparam int  BPB  = ADW / 8;
  localparam time TCLK = 10;
`ifdef AXIS_READ_SCHED_RRESP_EN
  localparam bit RRESP_ON = 1'b1;
`else
  localparam bit RRESP_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  axis_read_sched_if #(.CONFIG_AWIDTH(AW), .CONFIG_DWIDTH(DW), .AXI_LEN_WIDTH(LW)) bus_if ();

  axis_read_sched #(
    .CONFIG_AWIDTH(AW), .CONFIG_DWIDTH(DW), .WIDTH_RATIO(WR), .AXI_LEN_WIDTH(LW),
    .AXI_DATA_WIDTH(ADW), .BURST_MAX(BMAX), .OUTSTANDING(OUTS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #(TCLK / 2) clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];
  logic [AW-1:0] obs_addr[$];
  int            obs_len[$];
  int            pend[$];
  int            tb_inflight  = 0;
  int            rlast_cnt    = 0;
  int            beat_cnt     = 0;
  int            err_beat     = 0;
  bit            err_chk_next = 0;
  bit            r_en         = 1;
  bit            ar_rand      = 1;
  time           last_rlast_t = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected burst list: ceil(len/WR) beats cut at BURST_MAX and 4 KB edges.
  task automatic build_model(input logic [AW-1:0] a, input int unsigned len);
    longint unsigned rem, b, to_b, cur;
    exp_addr.delete();
    exp_len.delete();
    rem = (len == 0) ? 1 : (longint'(len) + WR - 1) / WR;
    cur = a;
    while (rem > 0) begin
      to_b = (4096 - (cur % 4096)) / BPB;
      b = rem;
      if (b > BMAX) b = BMAX;
      if (b > to_b) b = to_b;
      exp_addr.push_back(cur[AW-1:0]);
      exp_len.push_back(int'(b));
      cur = cur + b * BPB;
      rem = rem - b;
    end
  endtask

  // AR acceptor and R responder; all DUT inputs change on the falling edge.
  initial begin
    bit            prev_wait = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [LW-1:0] prev_len  = '0;
    bus_if.axi_arready = 1'b0;
    bus_if.axi_rvalid  = 1'b0;
    bus_if.axi_rready  = 1'b0;
    bus_if.axi_rlast   = 1'b0;
    bus_if.axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        tb_inflight = 0;
        prev_wait   = 0;
        bus_if.axi_arready = 1'b0;
        bus_if.axi_rvalid  = 1'b0;
        bus_if.axi_rlast   = 1'b0;
        continue;
      end
      if (err_chk_next) begin
        check("rresp_err_rise", bus_if.rresp_err, RRESP_ON);
        err_chk_next = 0;
      end
      bus_if.axi_rvalid = 1'b0;
      bus_if.axi_rlast  = ($urandom_range(0, 3) == 0);
      bus_if.axi_rresp  = 2'b00;
      bus_if.axi_rready = ($urandom_range(0, 3) != 0);
      if (r_en && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus_if.axi_rvalid = 1'b1;
        bus_if.axi_rlast  = (pend[0] == 1);
        if (bus_if.axi_rready) begin
          beat_cnt++;
          if (beat_cnt == err_beat) begin
            bus_if.axi_rresp = 2'b10;
            err_chk_next = 1;
          end
          pend[0] = pend[0] - 1;
          if (pend[0] == 0) begin
            void'(pend.pop_front());
            tb_inflight--;
            rlast_cnt++;
            last_rlast_t = $time;
          end
        end else begin
          bus_if.axi_rresp = 2'b11;
        end
      end
      bus_if.axi_arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (prev_wait) begin
        check("arvalid_hold", bus_if.axi_arvalid, 1);
        check("araddr_hold", bus_if.axi_araddr, prev_addr);
        check("arlen_hold", bus_if.axi_arlen, prev_len);
      end
      if (bus_if.axi_arvalid && bus_if.axi_arready) begin
        obs_addr.push_back(bus_if.axi_araddr);
        obs_len.push_back(int'(bus_if.axi_arlen) + 1);
        pend.push_back(int'(bus_if.axi_arlen) + 1);
        tb_inflight++;
        check("inflight_bound", tb_inflight <= OUTS, 1);
        prev_wait = 0;
      end else begin
        prev_wait = bus_if.axi_arvalid;
      end
      prev_addr = bus_if.axi_araddr;
      prev_len  = bus_if.axi_arlen;
    end
  end

  task automatic start_cmd(input logic [AW-1:0] a, input int unsigned len, input int dly,
                           input int err_b);
    int          cyc;
    int unsigned cfg_exp;
    cfg_exp = (len == 0) ? 1 : len;
    build_model(a, len);
    obs_addr.delete();
    obs_len.delete();
    rlast_cnt = 0;
    beat_cnt  = 0;
    err_beat  = err_b;
    cyc = 0;
    while (!bus_if.cfg_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("cfg_ready_idle", bus_if.cfg_ready, 1);
    bus_if.cfg_address    = a;
    bus_if.cfg_length     = len;
    bus_if.cfg_valid      = 1'b1;
    bus_if.data_cfg_ready = 1'b0;
    @(negedge clk);
    check("cfg_ready_busy", bus_if.cfg_ready, 0);
    check("data_cfg_valid", bus_if.data_cfg_valid, 1);
    check("data_cfg_length", bus_if.data_cfg_length, cfg_exp);
    check("rresp_err_clear", bus_if.rresp_err, 0);
    // A second command offered outside IDLE must be ignored.
    bus_if.cfg_address = a + 64;
    bus_if.cfg_length  = len + 5;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("dcfg_valid_hold", bus_if.data_cfg_valid, 1);
      check("dcfg_len_hold", bus_if.data_cfg_length, cfg_exp);
      check("no_ar_before_cfg", bus_if.axi_arvalid, 0);
    end
    bus_if.cfg_valid      = 1'b0;
    bus_if.data_cfg_ready = 1'b1;
    @(negedge clk);
    bus_if.data_cfg_ready = 1'b0;
    check("dcfg_valid_drop", bus_if.data_cfg_valid, 0);
    check("ar_latency_1", bus_if.axi_arvalid, 0);
    @(negedge clk);
    check("ar_latency_2", bus_if.axi_arvalid, 1);
  endtask

  task automatic finish_cmd(input int err_b);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus_if.done) got = 1;
    end
    check("done_seen", got, 1);
    check("done_after_rlast", $time - last_rlast_t, TCLK);
    check("rlast_count", rlast_cnt, exp_addr.size());
    check("cfg_ready_at_done", bus_if.cfg_ready, 1);
    check("burst_count", obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < obs_addr.size()) begin
        check("burst_addr", obs_addr[i], exp_addr[i]);
        check("burst_len", obs_len[i], exp_len[i]);
      end
    end
    check("rresp_err_end", bus_if.rresp_err, (err_b != 0) ? RRESP_ON : 1'b0);
    @(negedge clk);
    check("done_pulse", bus_if.done, 0);
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input int unsigned len, input int dly,
                         input int err_b);
    start_cmd(a, len, dly, err_b);
    finish_cmd(err_b);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus_if.cfg_address    = '0;
    bus_if.cfg_length     = '0;
    bus_if.cfg_valid      = 1'b0;
    bus_if.data_cfg_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cfg_ready", bus_if.cfg_ready, 1);
    check("rst_data_cfg_valid", bus_if.data_cfg_valid, 0);
    check("rst_arvalid", bus_if.axi_arvalid, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_rresp_err", bus_if.rresp_err, 0);
    check("arsize", bus_if.axi_arsize, 3'd2);
    check("arburst", bus_if.axi_arburst, 2'b01);
    #2 rst_n = 1'b1;

    ar_rand = 0;
    run_cmd(32'h0, 256, 0, 0);
    check("single_arlen", (obs_len.size() > 0) ? obs_len[0] - 1 : -1, 15);
    ar_rand = 1;
    run_cmd(32'h0000_0F80, 1024, 2, 0);
    run_cmd(32'h0000_0040, 17, 0, 0);
    check("odd_len_beats", (obs_len.size() > 0) ? obs_len[0] : 0, 2);
    run_cmd(32'h0000_0200, 100, 10, 0);
    run_cmd(32'h0000_0010, 0, 1, 0);
    run_cmd(32'h0000_0300, 200, 0, 3);

    // R channel stalled: only OUTSTANDING bursts may issue.
    ar_rand = 0;
    r_en    = 0;
    start_cmd(32'h0, 4096, 0, 0);
    repeat (20) @(negedge clk);
    check("stall_ar_count", obs_addr.size(), OUTS);
    check("stall_arvalid_low", bus_if.axi_arvalid, 0);
    r_en = 1;
    finish_cmd(0);

    // Reset while issuing addresses abandons the command.
    r_en = 0;
    start_cmd(32'h0000_0100, 4096, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_arvalid", bus_if.axi_arvalid, 0);
    check("rst_mid_cfg_ready", bus_if.cfg_ready, 1);
    check("rst_mid_done", bus_if.done, 0);
    repeat (2) @(negedge clk);
    obs_addr.delete();
    obs_len.delete();
    #2 rst_n = 1'b1;
    r_en = 1;
    repeat (6) @(negedge clk);
    check("no_ar_after_reset", obs_addr.size(), 0);
    check("idle_after_reset", bus_if.cfg_ready, 1);

    ar_rand = 1;
    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, 16383)) & ~AW'(3);
      run_cmd(ra, $urandom_range(1, 3000), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #(TCLK * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
